// File: rtl/divider_pkg.sv
// Shared definitions for the integer-N feedback divider built from the
// divide-by-3/4 prescaler and the pulse-swallow controller.
package divider_pkg;

    // Default width of the P/S program values and the period counter.
    localparam int WIDTH_DEFAULT = 8;

    // Encoding of the prescaler modulus control line.
    localparam logic MOD_DIV4 = 1'b1;
    localparam logic MOD_DIV3 = 1'b0;

    // Total division from the prescaler input for one program period:
    // S cycles of divide-by-4 plus (P - S) cycles of divide-by-3.
    function automatic int unsigned total_division(input int unsigned p,
                                                   input int unsigned s);
        return 3 * p + s;
    endfunction

endpackage

// File: rtl/swallow_cfg_reg.sv
// Configuration shadow register for the pulse-swallow controller.
// Accepts a new P/S pair over a valid/ready handshake, sanitises it, and
// holds it pending until the counter signals a period wrap via `apply`.
//
// Handshake: a transfer happens on a rising edge where cfg_valid and
// cfg_ready are both high. cfg_valid may be raised at any time and does not
// wait for cfg_ready. cfg_ready is low while a configuration is pending, so
// at most one configuration waits for the wrap; it returns high on the edge
// that applies the pending values.
module swallow_cfg_reg
    import divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [WIDTH-1:0] cfg_p,
    input  logic [WIDTH-1:0] cfg_s,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             apply,
    output logic [WIDTH-1:0] pend_p,
    output logic [WIDTH-1:0] pend_s,
    output logic             pending,
    output logic             cfg_clamped
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             accept;
    logic [WIDTH-1:0] san_p;
    logic [WIDTH-1:0] san_s;
    logic             p_clamp;
    logic             s_clamp;

    assign accept = cfg_valid & cfg_ready;

    // Sanitise the offered pair: P of zero becomes one, S is limited to the stored P.
    always_comb begin
        san_p   = cfg_p;
        p_clamp = 1'b0;
        if (cfg_p == '0) begin
            san_p   = ONE;
            p_clamp = 1'b1;
        end
        san_s   = cfg_s;
        s_clamp = 1'b0;
        if (cfg_s > san_p) begin
            san_s   = san_p;
            s_clamp = 1'b1;
        end
    end

    // Capture on accept, release on apply; ready mirrors "nothing pending".
    // An accept can only happen with nothing pending, so an accept that
    // coincides with a wrap is held for the following wrap.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pending     <= 1'b0;
            cfg_ready   <= 1'b1;
            cfg_clamped <= 1'b0;
            pend_p      <= ONE;
            pend_s      <= '0;
        end else begin
            cfg_clamped <= accept & (p_clamp | s_clamp);
            if (accept) begin
                pend_p    <= san_p;
                pend_s    <= san_s;
                pending   <= 1'b1;
                cfg_ready <= 1'b0;
            end else if (apply && pending) begin
                pending   <= 1'b0;
                cfg_ready <= 1'b1;
            end
        end
    end

    // Ready and pending are always complementary; stored S never exceeds stored P.
    a_ready_pending : assert property (@(posedge clk_in) disable iff (rst)
        cfg_ready == !pending);
    a_pend_sane : assert property (@(posedge clk_in) disable iff (rst)
        pending |-> (pend_p != '0 && pend_s <= pend_p));

endmodule

// File: rtl/pulse_swallow_ctrl.sv
// Programmable pulse-swallow controller driving the modulus input of a
// divide-by-3/4 prescaler. Each program period lasts P prescaler cycles;
// `mod` selects divide-by-4 for the first S of them, giving N = 3P + S.
// `div_out` marks the first cycle of every period.
module pulse_swallow_ctrl
    import divider_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int DEFAULT_P = 4,
    parameter int DEFAULT_S = 0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [WIDTH-1:0] cfg_p,
    input  logic [WIDTH-1:0] cfg_s,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_clamped,
    output logic             mod,
    output logic             div_out
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] RESET_P = WIDTH'(DEFAULT_P);
    localparam logic [WIDTH-1:0] RESET_S = WIDTH'(DEFAULT_S);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] p_act;
    logic [WIDTH-1:0] s_act;

    logic [WIDTH-1:0] pend_p;
    logic [WIDTH-1:0] pend_s;
    logic             pending;

    logic             wrap;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] s_next;
    logic             mod_next;

    // Handshake and sanitising shadow register; released at each wrap.
    swallow_cfg_reg #(
        .WIDTH(WIDTH)
    ) u_cfg (
        .clk_in      (clk_in),
        .rst         (rst),
        .cfg_p       (cfg_p),
        .cfg_s       (cfg_s),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .apply       (wrap),
        .pend_p      (pend_p),
        .pend_s      (pend_s),
        .pending     (pending),
        .cfg_clamped (cfg_clamped)
    );

    // Next counter position and the program that governs the next cycle.
    // mod for the next cycle is simply "position is inside the first S cycles",
    // using the program that will be active then (new values on a wrap).
    always_comb begin
        wrap     = (cnt == p_act - ONE);
        cnt_next = wrap ? '0 : cnt + ONE;
        p_next   = p_act;
        s_next   = s_act;
        if (wrap && pending) begin
            p_next = pend_p;
            s_next = pend_s;
        end
        mod_next = (cnt_next < s_next) ? MOD_DIV4 : MOD_DIV3;
    end

    // Counter, active program and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt     <= '0;
            p_act   <= RESET_P;
            s_act   <= RESET_S;
            mod     <= (DEFAULT_S != 0) ? MOD_DIV4 : MOD_DIV3;
            div_out <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            p_act   <= p_next;
            s_act   <= s_next;
            mod     <= mod_next;
            div_out <= wrap;
        end
    end

    // The counter stays inside the period and mod always tracks the position.
    a_cnt_in_range : assert property (@(posedge clk_in) disable iff (rst)
        cnt < p_act);
    a_mod_tracks : assert property (@(posedge clk_in) disable iff (rst)
        mod == (cnt < s_act));

endmodule

// File: tb/tb_pulse_swallow_ctrl.sv
// Bench for pulse_swallow_ctrl: a cycle model pushes the expected
// {cfg_ready, cfg_clamped, mod, div_out} per driven cycle and the expected
// division N per period; a prescaler model counts input clocks per period.
module tb_pulse_swallow_ctrl;
  import divider_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk_in = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] cfg_p = '0;
  logic [W-1:0] cfg_s = '0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic         cfg_clamped;
  logic         mod;
  logic         div_out;

  always #5 clk_in = ~clk_in;

  pulse_swallow_ctrl #(
    .WIDTH(W),
    .DEFAULT_P(4),
    .DEFAULT_S(0)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .cfg_p       (cfg_p),
    .cfg_s       (cfg_s),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_clamped (cfg_clamped),
    .mod         (mod),
    .div_out     (div_out)
  );

  // ---------------- scoreboard ----------------
  int n_compared = 0;
  int n_mismatched = 0;
  logic [3:0] exp_q[$];          // {cfg_ready, cfg_clamped, mod, div_out}
  int unsigned n_exp_q[$];       // expected N of each started period

  // reference model state
  int unsigned m_cnt, m_p, m_s, m_pp, m_ps;
  bit m_pend;

  // prescaler model: input clocks accumulated over the current period
  int unsigned acc = 0;
  bit armed = 0;

  typedef struct {
    logic         v;
    logic [W-1:0] p;
    logic [W-1:0] s;
    logic         r;
  } stim_t;
  stim_t st[$];

  function automatic void add(input logic v, input int unsigned p, input int unsigned s,
                              input logic r, input int n);
    stim_t e;
    e.v = v; e.p = W'(p); e.s = W'(s); e.r = r;
    for (int k = 0; k < n; k++) st.push_back(e);
  endfunction

  // Expected state after the coming edge, from the behavioural description.
  function automatic void model_push(input logic v, input int unsigned p,
                                     input int unsigned s, input logic r);
    bit accept, wrap, clamp;
    int unsigned sp, ss;
    if (r) begin
      m_cnt = 0; m_p = 4; m_s = 0; m_pend = 0;
      n_exp_q.delete();
      exp_q.push_back(4'b1000);
      return;
    end
    accept = v && !m_pend;
    wrap = (m_cnt + 1 == m_p);
    clamp = 0;
    if (wrap) begin
      m_cnt = 0;
      if (m_pend) begin
        m_p = m_pp; m_s = m_ps; m_pend = 0;
      end
      n_exp_q.push_back(total_division(m_p, m_s));
    end else begin
      m_cnt = m_cnt + 1;
    end
    if (accept) begin
      sp = (p == 0) ? 1 : p;
      ss = (s > sp) ? sp : s;
      clamp = (p == 0) || (s > sp);
      m_pp = sp; m_ps = ss; m_pend = 1;
    end
    exp_q.push_back({!m_pend, clamp, (m_cnt < m_s), wrap});
  endfunction

  // ---------------- driver ----------------
  task automatic tick(input logic v, input logic [W-1:0] p, input logic [W-1:0] s,
                      input logic r, output logic [3:0] obs, output bit n_done,
                      output int unsigned n_meas);
    rst = r; cfg_valid = v; cfg_p = p; cfg_s = s;
    model_push(v, int'(p), int'(s), r);
    @(posedge clk_in);
    #1;
    obs = {cfg_ready, cfg_clamped, mod, div_out};
    n_done = 0;
    n_meas = acc;
    if (r) begin
      armed = 0; acc = 0;
    end else begin
      if (div_out === 1'b1) begin
        n_done = armed; n_meas = acc; acc = 0; armed = 1;
      end
      acc += (mod === 1'b1) ? 4 : 3;
    end
  endtask

  logic [3:0] obs, exp;
  bit n_done;
  int unsigned n_meas, n_want;
  int clamp_pulses;

  // ---------------- tests ----------------
  task automatic test_reset();
    st.delete();
    add(0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 13);
    foreach (st[i]) begin
      tick(st[i].v, st[i].p, st[i].s, st[i].r, obs, n_done, n_meas);
      exp = exp_q.pop_front();
      n_compared++;
      if (obs !== exp) begin
        n_mismatched++;
        $display("FAIL reset cyc%0d {rdy,clmp,mod,div} got %b want %b", i, obs, exp);
      end
      if (n_done) begin
        n_compared++;
        n_want = (n_exp_q.size() > 0) ? n_exp_q.pop_front() : 0;
        if (n_meas !== n_want) begin
          n_mismatched++;
          $display("FAIL reset_N cyc%0d got %0d want %0d", i, n_meas, n_want);
        end
      end
    end
  endtask

  task automatic test_config();
    st.delete();
    add(1, 5, 2, 0, 1);
    add(0, 0, 0, 0, 16);
    foreach (st[i]) begin
      tick(st[i].v, st[i].p, st[i].s, st[i].r, obs, n_done, n_meas);
      exp = exp_q.pop_front();
      n_compared++;
      if (obs !== exp) begin
        n_mismatched++;
        $display("FAIL config_5_2 cyc%0d {rdy,clmp,mod,div} got %b want %b", i, obs, exp);
      end
      if (n_done) begin
        n_compared++;
        n_want = (n_exp_q.size() > 0) ? n_exp_q.pop_front() : 0;
        if (n_meas !== n_want) begin
          n_mismatched++;
          $display("FAIL config_5_2_N cyc%0d got %0d want %0d", i, n_meas, n_want);
        end
      end
    end
  endtask

  task automatic test_clamp();
    st.delete();
    add(1, 3, 7, 0, 1);
    add(0, 0, 0, 0, 12);
    clamp_pulses = 0;
    foreach (st[i]) begin
      tick(st[i].v, st[i].p, st[i].s, st[i].r, obs, n_done, n_meas);
      clamp_pulses += (obs[2] === 1'b1) ? 1 : 0;
      exp = exp_q.pop_front();
      n_compared++;
      if (obs !== exp) begin
        n_mismatched++;
        $display("FAIL clamp_3_7 cyc%0d {rdy,clmp,mod,div} got %b want %b", i, obs, exp);
      end
      if (n_done) begin
        n_compared++;
        n_want = (n_exp_q.size() > 0) ? n_exp_q.pop_front() : 0;
        if (n_meas !== n_want) begin
          n_mismatched++;
          $display("FAIL clamp_3_7_N cyc%0d got %0d want %0d", i, n_meas, n_want);
        end
      end
    end
    n_compared++;
    if (clamp_pulses !== 1) begin
      n_mismatched++;
      $display("FAIL clamp_3_7_pulses got %0d want 1", clamp_pulses);
    end
  endtask

  task automatic test_back_to_back();
    st.delete();
    add(0, 0, 0, 0, 2);
    add(1, 6, 3, 0, 1);
    add(1, 4, 1, 0, 10);
    add(0, 0, 0, 0, 12);
    foreach (st[i]) begin
      tick(st[i].v, st[i].p, st[i].s, st[i].r, obs, n_done, n_meas);
      exp = exp_q.pop_front();
      n_compared++;
      if (obs !== exp) begin
        n_mismatched++;
        $display("FAIL back_to_back cyc%0d {rdy,clmp,mod,div} got %b want %b", i, obs, exp);
      end
      if (n_done) begin
        n_compared++;
        n_want = (n_exp_q.size() > 0) ? n_exp_q.pop_front() : 0;
        if (n_meas !== n_want) begin
          n_mismatched++;
          $display("FAIL back_to_back_N cyc%0d got %0d want %0d", i, n_meas, n_want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    st.delete();
    add(0, 0, 0, 1, 1);   // known start: cnt 0, P=4 S=0
    add(1, 6, 3, 0, 1);   // accepted, applied at the wrap 3 cycles later
    add(0, 0, 0, 0, 3);
    add(1, 2, 2, 0, 1);   // pending during the P=6 period
    add(0, 0, 0, 0, 1);   // period cycle 2
    add(0, 0, 0, 1, 1);   // reset discards the pending pair
    add(0, 0, 0, 0, 10);
    foreach (st[i]) begin
      tick(st[i].v, st[i].p, st[i].s, st[i].r, obs, n_done, n_meas);
      exp = exp_q.pop_front();
      n_compared++;
      if (obs !== exp) begin
        n_mismatched++;
        $display("FAIL reset_mid cyc%0d {rdy,clmp,mod,div} got %b want %b", i, obs, exp);
      end
      if (n_done) begin
        n_compared++;
        n_want = (n_exp_q.size() > 0) ? n_exp_q.pop_front() : 0;
        if (n_meas !== n_want) begin
          n_mismatched++;
          $display("FAIL reset_mid_N cyc%0d got %0d want %0d", i, n_meas, n_want);
        end
      end
    end
  endtask

  task automatic test_p1();
    st.delete();
    add(1, 1, 1, 0, 1);
    add(0, 0, 0, 0, 8);
    add(1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 6);
    clamp_pulses = 0;
    foreach (st[i]) begin
      tick(st[i].v, st[i].p, st[i].s, st[i].r, obs, n_done, n_meas);
      clamp_pulses += (obs[2] === 1'b1) ? 1 : 0;
      exp = exp_q.pop_front();
      n_compared++;
      if (obs !== exp) begin
        n_mismatched++;
        $display("FAIL p1 cyc%0d {rdy,clmp,mod,div} got %b want %b", i, obs, exp);
      end
      if (n_done) begin
        n_compared++;
        n_want = (n_exp_q.size() > 0) ? n_exp_q.pop_front() : 0;
        if (n_meas !== n_want) begin
          n_mismatched++;
          $display("FAIL p1_N cyc%0d got %0d want %0d", i, n_meas, n_want);
        end
      end
    end
    n_compared++;
    if (clamp_pulses !== 1) begin
      n_mismatched++;
      $display("FAIL p1_clamp_pulses got %0d want 1", clamp_pulses);
    end
  endtask

  task automatic test_random();
    st.delete();
    for (int k = 0; k < 200; k++)
      add(($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom_range(0, 9),
          ($urandom_range(0, 79) == 0), 1);
    foreach (st[i]) begin
      tick(st[i].v, st[i].p, st[i].s, st[i].r, obs, n_done, n_meas);
      exp = exp_q.pop_front();
      n_compared++;
      if (obs !== exp) begin
        n_mismatched++;
        $display("FAIL random cyc%0d {rdy,clmp,mod,div} got %b want %b", i, obs, exp);
      end
      if (n_done) begin
        n_compared++;
        n_want = (n_exp_q.size() > 0) ? n_exp_q.pop_front() : 0;
        if (n_meas !== n_want) begin
          n_mismatched++;
          $display("FAIL random_N cyc%0d got %0d want %0d", i, n_meas, n_want);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_config();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_p1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
